if_id_queue: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 12 +
 rtl/if_id_queue_ram.sv | 26 ++
 rtl/if_id_queue.sv | 105 ++++++++++
 tb/tb_if_id_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the instruction word type and the bubble (nop) encoding.
// Included by pipeline blocks that need to emit a bubble when no instruction is available.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // An all-zero word decodes as a nop in this ISA.
    localparam word_t BUBBLE = '0;

endpackage

// File: rtl/if_id_queue_ram.sv
// Storage array for the IF/ID queue: one synchronous write port and one asynchronous read port.
// The array has no reset; the queue's pointers and count decide which entries are live.
module if_id_queue_ram #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [PW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch/decode decoupling FIFO of {instruction, PC+4} pairs with flush and bubble output.
// Optional same-cycle bypass when empty is enabled by defining IF_ID_QUEUE_BYPASS_EN.
module if_id_queue
    import cpu_types_pkg::*;
#(
    parameter int IW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ihit,
    input  logic [IW-1:0]              imemload,
    input  logic [AW-1:0]              pcp4,
    output logic                       full,
    input  logic                       deq,
    output logic                       valid,
    output logic [IW-1:0]              instr,
    output logic [AW-1:0]              pcp4_out,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int DW = IW + AW;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          empty;
    logic          bypass;
    logic          enq;
    logic          deq_fire;
    logic [DW-1:0] rd_data;
    logic [IW-1:0] head_instr;
    logic [AW-1:0] head_pcp4;

    // Handshake: fetch transfers when ihit=1 and full=0; decode transfers when valid=1 and deq=1.
    // full and valid come from registered state only, except valid/instr/pcp4_out on the bypass path.
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign bypass = empty & ihit & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word consumed in the same cycle never lands in storage.
    assign enq      = ihit & ~full & ~flush & ~(bypass & deq);
    assign deq_fire = deq & ~empty & ~flush;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= PW'(wr_ptr + 1'b1);
            end
            if (deq_fire) begin
                rd_ptr <= PW'(rd_ptr + 1'b1);
            end
            count_q <= CW'(count_q + CW'(enq) - CW'(deq_fire));
        end
    end

    if_id_queue_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_ram (
        .CLK   (CLK),
        .we    (enq),
        .waddr (wr_ptr),
        .wdata ({imemload, pcp4}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign head_instr = rd_data[DW-1:AW];
    assign head_pcp4  = rd_data[AW-1:0];

    assign valid = ~empty | bypass;

    always_comb begin
        instr    = IW'(BUBBLE);
        pcp4_out = '0;
        if (bypass) begin
            instr    = imemload;
            pcp4_out = pcp4;
        end else if (~empty) begin
            instr    = head_instr;
            pcp4_out = head_pcp4;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=4): fill, drop on full, wrap, flush, async reset, bypass.
// Inputs change on the falling edge; outputs are checked 1ns later, before the next rising edge.
module tb_if_id_queue;

    localparam int IW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          CLK;
    logic          RST;
    logic          ihit;
    logic [IW-1:0] imemload;
    logic [AW-1:0] pcp4;
    logic          full;
    logic          deq;
    logic          valid;
    logic [IW-1:0] instr;
    logic [AW-1:0] pcp4_out;
    logic          flush;
    logic [CW-1:0] count;

    logic [31:0] exp_q[$];
    int          checks;
    int          errors;

    if_id_queue #(
        .IW    (IW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ihit     (ihit),
        .imemload (imemload),
        .pcp4     (pcp4),
        .full     (full),
        .deq      (deq),
        .valid    (valid),
        .instr    (instr),
        .pcp4_out (pcp4_out),
        .flush    (flush),
        .count    (count)
    );

    // Clock and reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then settle before checking.
    task automatic step(input logic ih, input logic [31:0] d, input logic dq, input logic fl);
        @(negedge CLK);
        ihit     = ih;
        imemload = d;
        pcp4     = d + 32'h1000;
        deq      = dq;
        flush    = fl;
        #1;
    endtask

    // Compare the current head against the oldest expected entry and retire it.
    task automatic check_head(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed %h expected <empty scoreboard>", tag, instr);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 32'(valid), 32'd1);
            check({tag, "_instr"}, instr, e);
            check({tag, "_pcp4"}, pcp4_out, e + 32'h1000);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        RST      = 1'b1;
        ihit     = 1'b0;
        imemload = '0;
        pcp4     = '0;
        deq      = 1'b0;
        flush    = 1'b0;
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_instr", instr, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Fill to full, then a fifth word is dropped
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
            check("fill_count", 32'(count), 32'(i));
            exp_q.push_back(32'hA0 + 32'(i));
        end
        step(1'b1, 32'hA4, 1'b0, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count4", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            check_head("drain");
        end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("drain_valid", 32'(valid), 32'd0);
        check("drain_instr", instr, 32'd0);
        check("drain_pcp4", pcp4_out, 32'd0);
        check("drain_count", 32'(count), 32'd0);

        // Simultaneous enqueue/dequeue across pointer wrap
        step(1'b1, 32'hB0, 1'b0, 1'b0);
        exp_q.push_back(32'hB0);
        step(1'b1, 32'hB1, 1'b0, 1'b0);
        exp_q.push_back(32'hB1);
        for (int i = 2; i < 12; i++) begin
            step(1'b1, 32'hB0 + 32'(i), 1'b1, 1'b0);
            check("both_count", 32'(count), 32'd2);
            check_head("both");
            exp_q.push_back(32'hB0 + 32'(i));
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            check_head("both_drain");
        end

        // Full with simultaneous deq: new word is not written
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
            exp_q.push_back(32'hC0 + 32'(i));
        end
        step(1'b1, 32'hC4, 1'b1, 1'b0);
        check("fulldeq_full", 32'(full), 32'd1);
        check_head("fulldeq");
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("fulldeq_count", 32'(count), 32'd3);
        check("fulldeq_notfull", 32'(full), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            check_head("fulldeq_drain");
        end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("fulldeq_empty", 32'(valid), 32'd0);

        // Flush with ihit and deq in the same cycle
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hD0 + 32'(i), 1'b0, 1'b0);
        end
        step(1'b1, 32'hD3, 1'b1, 1'b1);
        check("flush_pre_count", 32'(count), 32'd3);
        step(1'b1, 32'hE0, 1'b0, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(valid), 32'd0);
        check("flush_instr", instr, 32'd0);
        check("flush_pcp4", pcp4_out, 32'd0);
        exp_q.push_back(32'hE0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check_head("post_flush");
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("post_flush_empty", 32'(valid), 32'd0);

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hF0 + 32'(i), 1'b0, 1'b0);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("mid_count", 32'(count), 32'd3);
        #2;
        RST = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_instr", instr, 32'd0);
        check("arst_pcp4", pcp4_out, 32'd0);
        check("arst_full", 32'(full), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Empty queue with ihit and deq in the same cycle
        step(1'b1, 32'h8C010004, 1'b1, 1'b0);
`ifdef IF_ID_QUEUE_BYPASS_EN
        check("byp_valid", 32'(valid), 32'd1);
        check("byp_instr", instr, 32'h8C010004);
        check("byp_pcp4", pcp4_out, 32'h8C011004);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("byp_count", 32'(count), 32'd0);
        check("byp_valid_after", 32'(valid), 32'd0);
`else
        check("nobyp_valid", 32'(valid), 32'd0);
        check("nobyp_instr", instr, 32'd0);
        exp_q.push_back(32'h8C010004);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("nobyp_count", 32'(count), 32'd1);
        check_head("nobyp_next");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
